// File: rtl/datapath_control_unit.sv
// datapath_control_unit
//   Hardwired Moore control sequencer for the phase-1 DataPath. It fetches an
//   instruction (T0..T2, with a WAIT loop on memory), decodes IR[31:27], and
//   sequences binary ALU, unary, mul/div, nop and halt instructions.
//
// Ports
//   clock      : system clock, rising-edge active
//   clear      : synchronous active-high reset
//   run        : level, permits fetching the next instruction
//   ir         : IR contents from the DataPath
//   mem_ready  : memory read data valid this cycle
//   PCout..Rout: DataPath strobes and select-and-encode register controls
//   alu_op     : opcode presented to the ALU in its Zin state, else 0
//   state      : current FSM state (debug)
//   instr_done : one-cycle pulse in the final execute state
//   halted     : high while in HALT
//   fault      : high while in FAULT (memory timeout)
module datapath_control_unit #(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           run,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           MARin,
  output logic           read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic [3:0]     state,
  output logic           instr_done,
  output logic           halted,
  output logic           fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_WAIT  = 4'd3,
    S_T2    = 4'd4,
    S_T3    = 4'd5,
    S_T4    = 4'd6,
    S_T5    = 4'd7,
    S_T6    = 4'd8,
    S_HALT  = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_BIN,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT
  } cls_t;

  function automatic cls_t classify(input logic [OPW-1:0] o);
    cls_t c;
    c = C_NOP;
    case (o)
      OPW'(5'b00011), OPW'(5'b00100), OPW'(5'b00101), OPW'(5'b00110),
      OPW'(5'b00111), OPW'(5'b01000), OPW'(5'b01001), OPW'(5'b01010):
        c = C_BIN;
      OPW'(5'b01111), OPW'(5'b10000): c = C_MULDIV;
      OPW'(5'b10001), OPW'(5'b10010): c = C_UNARY;
      OPW'(5'b11010):                 c = C_HALT;
      default:                        c = C_NOP;
    endcase
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [OPW-1:0] ir_op;
  cls_t           ir_cls;
  cls_t           op_cls;
  state_t         end_state;
  logic           unused_ir;

  assign ir_op     = ir[31 -: OPW];
  assign ir_cls    = classify(ir_op);
  assign op_cls    = classify(op_q);
  assign end_state = run ? S_T0 : S_IDLE;
  assign unused_ir = ^ir[31-OPW:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. In T2 the class comes straight from ir (the value being
  // latched into op on this edge); later states use the latched op.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (mem_ready)                      state_d = S_T2;
        else if (cnt_q == 8'(MEM_TIMEOUT))  state_d = S_FAULT;
        else                                cnt_d   = cnt_q + 8'd1;
      end
      S_T2: begin
        op_d = ir_op;
        case (ir_cls)
          C_HALT:  state_d = S_HALT;
          C_NOP:   state_d = end_state;
          default: state_d = S_T3;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = (op_cls == C_UNARY) ? end_state : S_T5;
      S_T5: state_d = (op_cls == C_MULDIV) ? S_T6 : end_state;
      S_T6: state_d = end_state;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    alu_op = '0;
    instr_done = 1'b0;
    halted = 1'b0;
    fault = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      S_WAIT: begin
        read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        instr_done = (ir_cls == C_NOP) || (ir_cls == C_HALT);
      end
      S_T3: begin
        Rout = 1'b1;
        case (op_cls)
          C_UNARY: begin
            Grb = 1'b1; Zin = 1'b1; alu_op = op_q;
          end
          C_MULDIV: begin
            Gra = 1'b1; Yin = 1'b1;
          end
          default: begin
            Grb = 1'b1; Yin = 1'b1;
          end
        endcase
      end
      S_T4: begin
        case (op_cls)
          C_UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          end
          C_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q;
          end
          default: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q;
          end
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_cls == C_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// tb_datapath_control_unit
//   Directed bench for datapath_control_unit. A behavioural model (expected
//   state plus a queue of remaining execute states) is compared against the
//   DUT every cycle; directed sequences also pin literal expectations.
module tb_datapath_control_unit;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, instr_done, halted, fault;
  logic [4:0] alu_op;
  logic [3:0] state;

  datapath_control_unit #(.OPW(5), .MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .state(state), .instr_done(instr_done),
    .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe vector bit positions.
  localparam int B_PCOUT = 21, B_PCIN = 20, B_INCPC = 19, B_MARIN = 18;
  localparam int B_READ = 17, B_MDRIN = 16, B_MDROUT = 15, B_IRIN = 14;
  localparam int B_YIN = 13, B_ZIN = 12, B_ZLO = 11, B_ZHI = 10;
  localparam int B_HIIN = 9, B_LOIN = 8, B_GRA = 7, B_GRB = 6, B_GRC = 5;
  localparam int B_RIN = 4, B_ROUT = 3, B_DONE = 2, B_HALT = 1, B_FAULT = 0;

  logic [21:0] act_vec;
  assign act_vec = {PCout, PCin, IncPC, MARin, read, MDRin, MDRout, IRin,
                    Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                    Gra, Grb, Grc, Rin, Rout, instr_done, halted, fault};

  localparam int CL_BIN = 0, CL_UN = 1, CL_MD = 2, CL_NOP = 3, CL_HALT = 4;

  function automatic int cls_of(input int op);
    if (op >= 3 && op <= 10) return CL_BIN;
    if (op == 15 || op == 16) return CL_MD;
    if (op == 17 || op == 18) return CL_UN;
    if (op == 26) return CL_HALT;
    return CL_NOP;
  endfunction

  // Execute steps after T2, as the list of states visited.
  function automatic int exec_len(input int cls);
    case (cls)
      CL_BIN: return 3;
      CL_UN:  return 2;
      CL_MD:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [21:0] exp_vec(input int st, input int cls);
    logic [21:0] v;
    v = '0;
    case (st)
      1: begin v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZIN] = 1; end
      2: begin v[B_ZLO] = 1; v[B_PCIN] = 1; v[B_READ] = 1; v[B_MDRIN] = 1; end
      3: begin v[B_READ] = 1; v[B_MDRIN] = 1; end
      4: begin
        v[B_MDROUT] = 1; v[B_IRIN] = 1;
        if (cls == CL_NOP || cls == CL_HALT) v[B_DONE] = 1;
      end
      9:  v[B_HALT] = 1;
      10: v[B_FAULT] = 1;
      default: begin
        // Execute step k = st-5 of the instruction's recipe.
        case (cls)
          CL_BIN: case (st)
            5: begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YIN] = 1; end
            6: begin v[B_GRC] = 1; v[B_ROUT] = 1; v[B_ZIN] = 1; end
            7: begin v[B_ZLO] = 1; v[B_GRA] = 1; v[B_RIN] = 1; v[B_DONE] = 1; end
            default: ;
          endcase
          CL_UN: case (st)
            5: begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_ZIN] = 1; end
            6: begin v[B_ZLO] = 1; v[B_GRA] = 1; v[B_RIN] = 1; v[B_DONE] = 1; end
            default: ;
          endcase
          CL_MD: case (st)
            5: begin v[B_GRA] = 1; v[B_ROUT] = 1; v[B_YIN] = 1; end
            6: begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_ZIN] = 1; end
            7: begin v[B_ZLO] = 1; v[B_LOIN] = 1; end
            8: begin v[B_ZHI] = 1; v[B_HIIN] = 1; v[B_DONE] = 1; end
            default: ;
          endcase
          default: ;
        endcase
      end
    endcase
    return v;
  endfunction

  // Behavioural model.
  int m_state = 0;
  int m_cnt   = 0;
  int m_op    = 0;
  int m_cls   = CL_NOP;
  int m_left  = 0;   // execute steps still to visit after the current one
  bit m_valid = 0;

  always @(posedge clock) begin
    if (clear) begin
      m_state = 0; m_cnt = 0; m_op = 0; m_cls = CL_NOP; m_left = 0;
      m_valid = 1;
    end else begin
      case (m_state)
        0: if (run) m_state = 1;
        1: m_state = 2;
        2: if (mem_ready) m_state = 4; else begin m_state = 3; m_cnt = 1; end
        3: begin
          if (mem_ready) m_state = 4;
          else if (m_cnt == TMO) m_state = 10;
          else m_cnt++;
        end
        4: begin
          m_op  = int'(ir[31:27]);
          m_cls = cls_of(m_op);
          if (m_cls == CL_HALT) m_state = 9;
          else if (exec_len(m_cls) == 0) m_state = run ? 1 : 0;
          else begin m_state = 5; m_left = exec_len(m_cls) - 1; end
        end
        9, 10: ;
        default: begin
          if (m_left > 0) begin m_state++; m_left--; end
          else m_state = run ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      int cls_now;
      int exp_alu;
      cls_now = (m_state == 4) ? cls_of(int'(ir[31:27])) : m_cls;
      exp_alu = 0;
      if ((m_state == 6 && (cls_now == CL_BIN || cls_now == CL_MD)) ||
          (m_state == 5 && cls_now == CL_UN))
        exp_alu = m_op;
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_strobes", 32'(act_vec), 32'(exp_vec(m_state, cls_now)));
      chk("model_alu_op", 32'(alu_op), 32'(exp_alu));
      if (Rin || Rout)
        chk("onehot_gr", 32'(Gra) + 32'(Grb) + 32'(Grc), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic step_to(input int s);
    tick();
    chk("seq_state", 32'(state), 32'(s));
  endtask

  initial begin
    clear = 1; run = 0; mem_ready = 1; ir = 32'h0;
    tick(); tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'(act_vec), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);

    // add, memory always ready
    clear = 0; run = 1; ir = 32'h1A000000;
    step_to(1); step_to(2); step_to(4); step_to(5); step_to(6);
    chk("add_t4_alu_op", 32'(alu_op), 32'd3);
    chk("add_t4_ctl", {Grc, Rout, Zin, Rin}, 4'b1110);
    step_to(7);
    chk("add_t5_ctl", {Gra, Rin, instr_done, Zlowout}, 4'b1111);
    step_to(1);
    chk("add_done_pulse", 32'(instr_done), 32'd0);

    // neg, 3 WAIT cycles
    ir = 32'h8A000000; mem_ready = 0;
    step_to(2);
    chk("neg_t1_pcin", 32'(PCin), 32'd1);
    step_to(3);
    chk("neg_wait_pcin", {PCin, read, MDRin}, 3'b011);
    step_to(3); step_to(3);
    mem_ready = 1;
    step_to(4); step_to(5);
    chk("neg_t3_alu_op", 32'(alu_op), 32'd17);
    step_to(6);
    chk("neg_t4_ctl", {Rin, instr_done}, 2'b11);
    step_to(1);

    // mul
    ir = 32'h78000000;
    step_to(2); step_to(4); step_to(5); step_to(6);
    chk("mul_t4_alu_op", 32'(alu_op), 32'd15);
    step_to(7);
    chk("mul_t5_ctl", {LOin, Zlowout, Rin}, 3'b110);
    step_to(8);
    chk("mul_t6_ctl", {HIin, Zhighout, Rin, instr_done}, 4'b1101);
    step_to(1);

    // illegal opcode behaves as nop
    ir = 32'hF8000000;
    step_to(2); step_to(4);
    chk("nop_t2_done", 32'(instr_done), 32'd1);
    step_to(1);

    // run dropped during T4 of add; clear during a later WAIT
    ir = 32'h1A000000;
    step_to(2); step_to(4); step_to(5); step_to(6);
    run = 0;
    step_to(7);
    chk("rundrop_t5_done", 32'(instr_done), 32'd1);
    step_to(0);
    run = 1; mem_ready = 0;
    step_to(1); step_to(2); step_to(3);
    clear = 1;
    step_to(0);
    chk("midwait_clear_strobes", 32'(act_vec), 32'd0);

    // memory timeout
    clear = 0;
    step_to(1); step_to(2);
    for (int unsigned i = 0; i < TMO; i++) step_to(3);
    step_to(10);
    chk("timeout_fault", 32'(fault), 32'd1);
    mem_ready = 1;
    step_to(10); step_to(10);
    clear = 1;
    step_to(0);

    // halt is sticky
    clear = 0; ir = 32'hD0000000;
    step_to(1); step_to(2); step_to(4);
    chk("halt_t2_done", 32'(instr_done), 32'd1);
    step_to(9);
    chk("halted", 32'(halted), 32'd1);
    mem_ready = 0;
    step_to(9); step_to(9);
    clear = 1;
    step_to(0);
    clear = 0; run = 0;
    step_to(0); step_to(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
